// File: rtl/ac_motor_svm_time_calc.sv
// Space-vector dwell-time calculator: one shared multiplier sequenced by an FSM,
// with minimum-pulse dropping, overmodulation clamping and a per-result saturation flag.
module ac_motor_svm_time_calc #(
    parameter int W      = 12,
    parameter int TW     = 15,
    parameter int PERIOD = 20000,
    parameter int TMIN   = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  u_str,
    input  logic [W-1:0]  sine_pos,
    input  logic [W-1:0]  sine_neg,
    input  logic [2:0]    sector,
    output logic          busy,
    output logic          done,
    output logic [TW-1:0] t0,
    output logic [TW-1:0] t1,
    output logic [TW-1:0] t2,
    output logic [TW-1:0] t7,
    output logic [2:0]    sector_out,
    output logic          sat
);

    localparam int BW = (W > TW) ? W : TW;
    localparam int PW = W + BW;
    localparam logic [TW-1:0] PERIOD_T = TW'(PERIOD);
    localparam logic [TW-1:0] TMIN_T   = TW'(TMIN);
    localparam logic [TW-1:0] T0_RST   = TW'(PERIOD - PERIOD / 2);
    localparam logic [TW-1:0] T7_RST   = TW'(PERIOD / 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MUL_A1 = 3'd1,
        S_MUL_B1 = 3'd2,
        S_MUL_A2 = 3'd3,
        S_MUL_B2 = 3'd4,
        S_ADJ    = 3'd5,
        S_SPLIT  = 3'd6
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]  u_q, u_d, sp_q, sp_d, sn_q, sn_d, a_q, a_d;
    logic [2:0]    sec_q, sec_d, sector_out_q, sector_out_d;
    logic [TW-1:0] t1r_q, t1r_d, t2r_q, t2r_d;
    logic          satr_q, satr_d, sat_q, sat_d, done_q, done_d;
    logic [TW-1:0] t0_q, t0_d, t1_q, t1_d, t2_q, t2_d, t7_q, t7_d;

    logic [W-1:0]  mul_a_s;
    logic [BW-1:0] mul_b_s, mul_hi_s;
    logic [PW-1:0] mul_p_s;
    logic          t1_below_s, t2_below_s;
    logic [TW-1:0] t1_drop_s, t2_drop_s, z_s, half_s;
    logic [TW:0]   sum_s;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed one-state-per-cycle sequence after an accepted start
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_MUL_A1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL_A1: state_d = S_MUL_B1;
            S_MUL_B1: state_d = S_MUL_A2;
            S_MUL_A2: state_d = S_MUL_B2;
            S_MUL_B2: state_d = S_ADJ;
            S_ADJ:    state_d = S_SPLIT;
            S_SPLIT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Shared multiplier operand selection; the upper half is the scaled result
    always_comb begin
        mul_a_s = {W{1'b0}};
        mul_b_s = {BW{1'b0}};
        case (state_q)
            S_MUL_A1: begin
                mul_a_s = u_q;
                mul_b_s = BW'(sp_q);
            end
            S_MUL_A2: begin
                mul_a_s = u_q;
                mul_b_s = BW'(sn_q);
            end
            S_MUL_B1, S_MUL_B2: begin
                mul_a_s = a_q;
                mul_b_s = BW'(PERIOD_T);
            end
            default: begin
                mul_a_s = {W{1'b0}};
                mul_b_s = {BW{1'b0}};
            end
        endcase
        mul_p_s  = PW'(mul_a_s) * PW'(mul_b_s);
        mul_hi_s = BW'(mul_p_s >> W);
    end

    // Adjust and split arithmetic; the borrow of t - TMIN flags a too-short pulse
    always_comb begin
        t1_below_s = |(({1'b0, t1r_q} - {1'b0, TMIN_T}) >> TW);
        t2_below_s = |(({1'b0, t2r_q} - {1'b0, TMIN_T}) >> TW);
        t1_drop_s  = t1_below_s ? {TW{1'b0}} : t1r_q;
        t2_drop_s  = t2_below_s ? {TW{1'b0}} : t2r_q;
        sum_s      = {1'b0, t1_drop_s} + {1'b0, t2_drop_s};
        z_s        = PERIOD_T - t1r_q - t2r_q;
        half_s     = z_s >> 1;
    end

    // Datapath next-state: latch request, run the multiply sequence, publish in SPLIT
    always_comb begin
        u_d          = u_q;
        sp_d         = sp_q;
        sn_d         = sn_q;
        sec_d        = sec_q;
        a_d          = a_q;
        t1r_d        = t1r_q;
        t2r_d        = t2r_q;
        satr_d       = satr_q;
        t0_d         = t0_q;
        t1_d         = t1_q;
        t2_d         = t2_q;
        t7_d         = t7_q;
        sat_d        = sat_q;
        sector_out_d = sector_out_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    u_d   = u_str;
                    sp_d  = sine_pos;
                    sn_d  = sine_neg;
                    sec_d = sector;
                end else begin
                    u_d   = u_q;
                end
            end
            S_MUL_A1, S_MUL_A2: a_d   = mul_hi_s[W-1:0];
            S_MUL_B1:           t1r_d = mul_hi_s[TW-1:0];
            S_MUL_B2:           t2r_d = mul_hi_s[TW-1:0];
            S_ADJ: begin
                t1r_d = t1_drop_s;
                // t1 never exceeds PERIOD, so the clamped t2 cannot underflow
                if (sum_s > {1'b0, PERIOD_T}) begin
                    t2r_d  = PERIOD_T - t1_drop_s;
                    satr_d = 1'b1;
                end else begin
                    t2r_d  = t2_drop_s;
                    satr_d = 1'b0;
                end
            end
            S_SPLIT: begin
                t0_d         = z_s - half_s;
                t7_d         = half_s;
                t1_d         = t1r_q;
                t2_d         = t2r_q;
                sat_d        = satr_q;
                sector_out_d = sec_q;
                done_d       = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset yields the safe all-zero-vector output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            u_q          <= {W{1'b0}};
            sp_q         <= {W{1'b0}};
            sn_q         <= {W{1'b0}};
            sec_q        <= 3'd0;
            a_q          <= {W{1'b0}};
            t1r_q        <= {TW{1'b0}};
            t2r_q        <= {TW{1'b0}};
            satr_q       <= 1'b0;
            t0_q         <= T0_RST;
            t1_q         <= {TW{1'b0}};
            t2_q         <= {TW{1'b0}};
            t7_q         <= T7_RST;
            sat_q        <= 1'b0;
            sector_out_q <= 3'd0;
            done_q       <= 1'b0;
        end else begin
            u_q          <= u_d;
            sp_q         <= sp_d;
            sn_q         <= sn_d;
            sec_q        <= sec_d;
            a_q          <= a_d;
            t1r_q        <= t1r_d;
            t2r_q        <= t2r_d;
            satr_q       <= satr_d;
            t0_q         <= t0_d;
            t1_q         <= t1_d;
            t2_q         <= t2_d;
            t7_q         <= t7_d;
            sat_q        <= sat_d;
            sector_out_q <= sector_out_d;
            done_q       <= done_d;
        end
    end

    assign done       = done_q;
    assign t0         = t0_q;
    assign t1         = t1_q;
    assign t2         = t2_q;
    assign t7         = t7_q;
    assign sat        = sat_q;
    assign sector_out = sector_out_q;

endmodule

// File: tb/tb_ac_motor_svm_time_calc.sv
// Scoreboard bench for ac_motor_svm_time_calc: two instances (TMIN=0 and TMIN=16)
// share stimulus; monitors pop expected results on every done pulse.
module tb_ac_motor_svm_time_calc;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] u_str, sine_pos, sine_neg;
    logic [2:0]  sector;

    logic        busy_a, done_a, sat_a;
    logic [14:0] t0_a, t1_a, t2_a, t7_a;
    logic [2:0]  sec_a;
    logic        busy_b, done_b, sat_b;
    logic [14:0] t0_b, t1_b, t2_b, t7_b;
    logic [2:0]  sec_b;

    typedef struct {
        int t0; int t1; int t2; int t7; int sat; int sec; int k;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_prev = 0;
    int   done_last = 0;

    ac_motor_svm_time_calc #(.W(12), .TW(15), .PERIOD(20000), .TMIN(0)) dut (
        .clk(clk), .reset(reset), .start(start), .u_str(u_str),
        .sine_pos(sine_pos), .sine_neg(sine_neg), .sector(sector),
        .busy(busy_a), .done(done_a), .t0(t0_a), .t1(t1_a), .t2(t2_a),
        .t7(t7_a), .sector_out(sec_a), .sat(sat_a)
    );

    ac_motor_svm_time_calc #(.W(12), .TW(15), .PERIOD(20000), .TMIN(16)) dut16 (
        .clk(clk), .reset(reset), .start(start), .u_str(u_str),
        .sine_pos(sine_pos), .sine_neg(sine_neg), .sector(sector),
        .busy(busy_b), .done(done_b), .t0(t0_b), .t1(t1_b), .t2(t2_b),
        .t7(t7_b), .sector_out(sec_b), .sat(sat_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input int t0v, input int t1v, input int t2v,
                                input int t7v, input int satv, input int secv);
        exp_t e;
        e.t0 = t0v; e.t1 = t1v; e.t2 = t2v; e.t7 = t7v;
        e.sat = satv; e.sec = secv; e.k = 0;
        return e;
    endfunction

    function automatic exp_t model(input int u, input int sp, input int sn,
                                   input int sec, input int tmin);
        longint a1, a2, r1, r2, z, h;
        int s;
        a1 = (longint'(u) * longint'(sp)) / 4096;
        r1 = (a1 * 20000) / 4096;
        a2 = (longint'(u) * longint'(sn)) / 4096;
        r2 = (a2 * 20000) / 4096;
        if (r1 < tmin) r1 = 0;
        if (r2 < tmin) r2 = 0;
        s = 0;
        if (r1 + r2 > 20000) begin
            r2 = 20000 - r1;
            s = 1;
        end
        z = 20000 - r1 - r2;
        h = z / 2;
        return mk(int'(z - h), int'(r1), int'(r2), int'(h), s, sec);
    endfunction

    task automatic compare(input string tag, input exp_t e, input int t0v, input int t1v,
                           input int t2v, input int t7v, input int satv, input int secv);
        chk({tag, "_t0"}, t0v, e.t0);
        chk({tag, "_t1"}, t1v, e.t1);
        chk({tag, "_t2"}, t2v, e.t2);
        chk({tag, "_t7"}, t7v, e.t7);
        chk({tag, "_sat"}, satv, e.sat);
        chk({tag, "_sector"}, secv, e.sec);
        chk({tag, "_latency"}, cyc - e.k, 6);
        chk({tag, "_sum"}, t0v + t1v + t2v + t7v, 20000);
        chk({tag, "_t0_t7_diff_ok"}, int'((t0v - t7v == 0) || (t0v - t7v == 1)), 1);
    endtask

    // Monitor for the TMIN=0 instance
    always @(negedge clk) begin
        if (done_a) begin
            done_prev = done_last;
            done_last = cyc;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done_a actual=done required=no_done");
            end else begin
                compare("a", q_a.pop_front(), int'(t0_a), int'(t1_a), int'(t2_a),
                        int'(t7_a), int'(sat_a), int'(sec_a));
            end
        end
    end

    // Monitor for the TMIN=16 instance
    always @(negedge clk) begin
        if (done_b) begin
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done_b actual=done required=no_done");
            end else begin
                compare("b", q_b.pop_front(), int'(t0_b), int'(t1_b), int'(t2_b),
                        int'(t7_b), int'(sat_b), int'(sec_b));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_a && n < 20) begin
            tick();
            n++;
        end
        if (busy_a) begin
            errors++;
            $display("FAIL wait_idle actual=busy required=idle");
        end
    endtask

    task automatic issue(input int u, input int sp, input int sn, input int sec,
                         input exp_t ea, input exp_t eb);
        wait_idle();
        u_str = 12'(u); sine_pos = 12'(sp); sine_neg = 12'(sn); sector = 3'(sec);
        start = 1'b1;
        ea.k = cyc + 1;
        eb.k = cyc + 1;
        q_a.push_back(ea);
        q_b.push_back(eb);
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_pending", q_a.size() + q_b.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_t0"}, int'(t0_a), 10000);
        chk({nm, "_t7"}, int'(t7_a), 10000);
        chk({nm, "_t1"}, int'(t1_a), 0);
        chk({nm, "_t2"}, int'(t2_a), 0);
        chk({nm, "_sat"}, int'(sat_a), 0);
        chk({nm, "_sector"}, int'(sec_a), 0);
        chk({nm, "_busy"}, int'(busy_a), 0);
        chk({nm, "_done"}, int'(done_a), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        u_str = 12'd0; sine_pos = 12'd0; sine_neg = 12'd0; sector = 3'd0;
        tick();
        chk_reset_outputs("reset");
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("idle");

        // Abort mid-calculation: no done expected, outputs back to reset values
        u_str = 12'd2048; sine_pos = 12'd2048; sine_neg = 12'd4; sector = 3'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk_reset_outputs("midcalc_reset");
        tick();
        reset = 1'b0;
        repeat (10) tick();

        // Directed vectors with hand-computed results
        issue(4095, 4095, 0, 2, mk(5, 19990, 0, 5, 0, 2), mk(5, 19990, 0, 5, 0, 2));
        issue(0, 1234, 3000, 5, mk(10000, 0, 0, 10000, 0, 5), mk(10000, 0, 0, 10000, 0, 5));
        issue(2048, 2048, 4, 1, mk(7496, 5000, 9, 7495, 0, 1), mk(7500, 5000, 0, 7500, 0, 1));
        issue(4095, 4095, 4095, 7, mk(0, 19990, 10, 0, 1, 7), mk(0, 19990, 10, 0, 1, 7));
        issue(100, 100, 4095, 6, mk(9754, 9, 483, 9754, 0, 6), mk(9759, 0, 483, 9758, 0, 6));
        drain();

        // Start pulse while busy must be ignored
        issue(2048, 2048, 4, 4, mk(7496, 5000, 9, 7495, 0, 4), mk(7500, 5000, 0, 7500, 0, 4));
        tick();
        u_str = 12'd4095; sine_pos = 12'd4095; sine_neg = 12'd4095; sector = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_during_ignored_start", int'(busy_a), 1);
        drain();
        repeat (10) tick();

        // Back-to-back: second request accepted in the done cycle
        issue(4095, 4095, 0, 2, mk(5, 19990, 0, 5, 0, 2), mk(5, 19990, 0, 5, 0, 2));
        issue(0, 7, 9, 3, mk(10000, 0, 0, 10000, 0, 3), mk(10000, 0, 0, 10000, 0, 3));
        drain();
        chk("back_to_back_spacing", done_last - done_prev, 7);

        // Randomised requests against the arithmetic model
        for (int i = 0; i < 1000; i++) begin
            int u, sp, sn, sec;
            u   = int'($urandom_range(0, 4095));
            sp  = int'($urandom_range(0, 4095));
            sn  = int'($urandom_range(0, 4095));
            sec = int'($urandom_range(0, 7));
            issue(u, sp, sn, sec, model(u, sp, sn, sec, 0), model(u, sp, sn, sec, 16));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
